// File: rtl/fetch_ctl.sv
// fetch_ctl: instruction-fetch sequencer with one outstanding imem request,
// trap/branch redirects, decode-backpressure hold and fetch fault generation.
`default_nettype none

module fetch_ctl #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_0000_1000,
    parameter logic [4:0]  CAUSE_MISAL = 5'd0,
    parameter logic [4:0]  CAUSE_IPF   = 5'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    input  logic        bj_en,
    input  logic [63:0] bj_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_fault,
    output logic [63:0] pc,
    output logic [31:0] inst,
    output logic        invalid,
    output logic        page_fault,
    output logic [4:0]  cause,
    output logic [63:0] tval
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [63:0] r_fpc;
    logic [63:0] w_next_fpc;
    logic        w_redirect;
    logic [63:0] w_target;
    logic        w_accept;

    assign w_redirect = trap_en | bj_en;
    assign w_target   = trap_en ? trap_pc : bj_pc;
    // imem_req is registered, so a grant only counts while it is actually driven
    assign w_accept   = (r_state == S_REQ) && imem_req && imem_gnt;

    always_comb begin
        w_next_state = r_state;
        w_next_fpc   = r_fpc;
        if (w_redirect) begin
            w_next_fpc = w_target;
            if ((r_state == S_WAIT) || (r_state == S_DRAIN) || w_accept)
                w_next_state = S_DRAIN;
            else
                w_next_state = S_REQ;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (r_fpc[1:0] != 2'b00)
                        w_next_state = S_HALT;
                    else if (w_accept)
                        w_next_state = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (imem_fault) begin
                            w_next_state = S_HALT;
                        end else if (stall) begin
                            w_next_state = S_HOLD;
                        end else begin
                            w_next_fpc   = r_fpc + 64'd4;
                            w_next_state = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_next_fpc   = r_fpc + 64'd4;
                        w_next_state = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid)
                        w_next_state = S_REQ;
                end
                S_HALT:  w_next_state = S_HALT;
                default: w_next_state = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fpc      <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            pc         <= 64'd0;
            inst       <= NOP;
            invalid    <= 1'b1;
            page_fault <= 1'b0;
            cause      <= 5'd0;
            tval       <= 64'd0;
        end else begin
            r_state   <= w_next_state;
            r_fpc     <= w_next_fpc;
            imem_req  <= (w_next_state == S_REQ) && (w_next_fpc[1:0] == 2'b00);
            imem_addr <= w_next_fpc;
            if (w_redirect) begin
                invalid    <= 1'b1;
                page_fault <= 1'b0;
                inst       <= NOP;
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (r_fpc[1:0] != 2'b00) begin
                            pc         <= r_fpc;
                            inst       <= NOP;
                            invalid    <= 1'b0;
                            page_fault <= 1'b1;
                            cause      <= CAUSE_MISAL;
                            tval       <= r_fpc;
                        end else begin
                            invalid    <= 1'b1;
                            page_fault <= 1'b0;
                            inst       <= NOP;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid && imem_fault) begin
                            pc         <= r_fpc;
                            inst       <= NOP;
                            invalid    <= 1'b0;
                            page_fault <= 1'b1;
                            cause      <= CAUSE_IPF;
                            tval       <= r_fpc;
                        end else if (imem_rvalid) begin
                            // output registers double as the hold buffer under stall
                            pc         <= r_fpc;
                            inst       <= imem_rdata;
                            invalid    <= 1'b0;
                            page_fault <= 1'b0;
                        end else begin
                            invalid    <= 1'b1;
                            page_fault <= 1'b0;
                            inst       <= NOP;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            invalid    <= 1'b1;
                            page_fault <= 1'b0;
                            inst       <= NOP;
                        end
                    end
                    S_HALT: begin
                        invalid <= invalid;
                    end
                    default: begin
                        invalid    <= 1'b1;
                        page_fault <= 1'b0;
                        inst       <= NOP;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctl.sv
// tb_fetch_ctl: directed stimulus for fetch_ctl, checked every cycle against a
// flag-based behavioural model plus hand-computed literal expectations.
`default_nettype none

module tb_fetch_ctl;

    logic        clk = 1'b0;
    logic        rst, trap_en, bj_en, stall;
    logic [63:0] trap_pc, bj_pc;
    logic        imem_gnt, imem_rvalid, imem_fault;
    logic [31:0] imem_rdata;
    logic        imem_req, invalid, page_fault;
    logic [63:0] imem_addr, pc, tval;
    logic [31:0] inst;
    logic [4:0]  cause;

    int checks   = 0;
    int failures = 0;

    // model: fetch pc plus a few flags describing what is in flight
    logic [63:0] m_fpc;
    bit          m_busy, m_drop, m_held, m_halt, m_warm;
    logic        e_req, e_invalid, e_pf;
    logic [63:0] e_addr, e_pc, e_tval;
    logic [31:0] e_inst;
    logic [4:0]  e_cause;

    always #5 clk = ~clk;

    fetch_ctl dut (
        .clk(clk), .rst(rst), .trap_en(trap_en), .trap_pc(trap_pc),
        .bj_en(bj_en), .bj_pc(bj_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_fault(imem_fault),
        .pc(pc), .inst(inst), .invalid(invalid), .page_fault(page_fault),
        .cause(cause), .tval(tval)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic present_fault(input logic [4:0] c);
        m_halt = 1; e_pf = 1; e_invalid = 0; e_inst = 32'h13;
        e_pc = m_fpc; e_cause = c; e_tval = m_fpc;
    endtask

    task automatic bubble();
        e_invalid = 1; e_pf = 0; e_inst = 32'h13;
    endtask

    task automatic model_step();
        bit accepted;
        accepted = e_req && imem_gnt;
        if (rst) begin
            m_fpc = 64'h1000; m_busy = 0; m_drop = 0; m_held = 0; m_halt = 0; m_warm = 0;
            e_pc = 0; e_cause = 0; e_tval = 0;
            bubble();
        end else begin
            if (trap_en || bj_en) begin
                m_fpc  = trap_en ? trap_pc : bj_pc;
                m_drop = m_busy || m_drop || accepted;
                m_busy = 0; m_held = 0; m_halt = 0;
                bubble();
            end else if (m_drop) begin
                if (imem_rvalid) m_drop = 0;
                bubble();
            end else if (m_halt) begin
                // fault stays on display
            end else if (m_held) begin
                if (!stall) begin
                    m_held = 0; m_fpc = m_fpc + 64'd4;
                    bubble();
                end
            end else if (m_busy) begin
                if (imem_rvalid) begin
                    m_busy = 0;
                    if (imem_fault) present_fault(5'd12);
                    else begin
                        e_pc = m_fpc; e_inst = imem_rdata; e_invalid = 0; e_pf = 0;
                        if (stall) m_held = 1;
                        else m_fpc = m_fpc + 64'd4;
                    end
                end else bubble();
            end else begin
                if (m_fpc[1:0] != 2'b00) present_fault(5'd0);
                else begin
                    if (accepted) m_busy = 1;
                    bubble();
                end
            end
            m_warm = 1;
        end
        e_addr = m_fpc;
        e_req  = m_warm && !m_busy && !m_drop && !m_held && !m_halt && (m_fpc[1:0] == 2'b00);
    endtask

    task automatic compare();
        chk("imem_req", {63'd0, imem_req}, {63'd0, e_req});
        chk("imem_addr", imem_addr, e_addr);
        chk("invalid", {63'd0, invalid}, {63'd0, e_invalid});
        chk("page_fault", {63'd0, page_fault}, {63'd0, e_pf});
        chk("inst", {32'd0, inst}, {32'd0, e_inst});
        if (!e_invalid) chk("pc", pc, e_pc);
        if (e_pf) begin
            chk("cause", {59'd0, cause}, {59'd0, e_cause});
            chk("tval", tval, e_tval);
        end
    endtask

    task automatic clr();
        rst = 0; trap_en = 0; bj_en = 0; stall = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_fault = 0; imem_rdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        clr();
    endtask

    initial begin
        clr();
        trap_pc = 0; bj_pc = 0;
        rst = 1; tick();
        rst = 1; tick();
        chk("lit_rst_req", {63'd0, imem_req}, 64'd0);
        chk("lit_rst_addr", imem_addr, 64'h1000);
        chk("lit_rst_pc", pc, 64'd0);
        chk("lit_rst_invalid", {63'd0, invalid}, 64'd1);
        tick();
        chk("lit_first_req", {63'd0, imem_req}, 64'd1);

        // grant and response each one cycle late
        tick();
        imem_gnt = 1; tick();
        tick();
        imem_rvalid = 1; imem_rdata = 32'h0000_0297; tick();
        chk("lit_word_pc", pc, 64'h1000);
        chk("lit_word_inst", {32'd0, inst}, 64'h297);
        chk("lit_word_invalid", {63'd0, invalid}, 64'd0);
        chk("lit_next_addr", imem_addr, 64'h1004);

        // response under stall: frozen for three cycles
        imem_gnt = 1; tick();
        imem_rvalid = 1; imem_rdata = 32'hAAAA_5555; stall = 1; tick();
        for (int i = 0; i < 2; i++) begin
            stall = 1; tick();
            chk("lit_hold_inst", {32'd0, inst}, 64'hAAAA_5555);
            chk("lit_hold_req", {63'd0, imem_req}, 64'd0);
        end
        tick();
        chk("lit_release_addr", imem_addr, 64'h1008);

        // branch while waiting: next response dropped
        imem_gnt = 1; tick();
        bj_en = 1; bj_pc = 64'h2000; tick();
        imem_rvalid = 1; imem_rdata = 32'h1111_1111; tick();
        chk("lit_drain_invalid", {63'd0, invalid}, 64'd1);
        chk("lit_drain_addr", imem_addr, 64'h2000);

        // trap beats branch
        trap_en = 1; trap_pc = 64'h8000_0000; bj_en = 1; bj_pc = 64'h3000; tick();
        chk("lit_prio_addr", imem_addr, 64'h8000_0000);

        // redirect in the same cycle a grant lands
        imem_gnt = 1; bj_en = 1; bj_pc = 64'h5000; tick();
        tick();
        imem_rvalid = 1; tick();
        chk("lit_gnt_redirect_addr", imem_addr, 64'h5000);

        // page fault, held across stall, then misaligned redirect
        bj_en = 1; bj_pc = 64'h4000; tick();
        imem_gnt = 1; tick();
        imem_rvalid = 1; imem_fault = 1; tick();
        stall = 1; tick();
        tick();
        chk("lit_ipf_cause", {59'd0, cause}, 64'd12);
        chk("lit_ipf_tval", tval, 64'h4000);
        trap_en = 1; trap_pc = 64'h4002; tick();
        tick();
        chk("lit_mis_cause", {59'd0, cause}, 64'd0);
        chk("lit_mis_tval", tval, 64'h4002);
        stall = 1; tick();
        chk("lit_mis_req", {63'd0, imem_req}, 64'd0);

        // top-of-address-space wrap
        trap_en = 1; trap_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick();
        imem_gnt = 1; tick();
        imem_rvalid = 1; imem_rdata = 32'h0000_0033; tick();
        chk("lit_wrap_addr", imem_addr, 64'h0);
        chk("lit_wrap_pf", {63'd0, page_fault}, 64'd0);

        // zero-wait memory stream
        for (int i = 0; i < 4; i++) begin
            imem_gnt = 1; tick();
            imem_rvalid = 1; imem_rdata = 32'h100 + i; tick();
        end
        chk("lit_stream_addr", imem_addr, 64'h10);

        // reset while a response is outstanding
        imem_gnt = 1; tick();
        rst = 1; tick();
        chk("lit_rst2_addr", imem_addr, 64'h1000);
        chk("lit_rst2_req", {63'd0, imem_req}, 64'd0);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick();
        chk("lit_rst2_invalid", {63'd0, invalid}, 64'd1);
        chk("lit_rst2_req_again", {63'd0, imem_req}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
